// File: rtl/smaesh_share_feeder_if.sv
// rtl/smaesh_share_feeder_if.sv - handshake bundle between the share feeder and its producer/consumer
interface smaesh_share_feeder_if #(
  parameter int d = 2
);
  logic             in_key_valid;
  logic             in_key_ready;
  logic [31:0]      in_key_data;
  logic [1:0]       in_key_size_cfg;
  logic             in_key_mode_inverse;
  logic             in_data_valid;
  logic             in_data_ready;
  logic [127:0]     in_data;
  logic             in_rnd_valid;
  logic             in_rnd_ready;
  logic [31:0]      in_rnd;
  logic             out_key_valid;
  logic             out_key_ready;
  logic [31:0]      out_key_data;
  logic [1:0]       out_key_size_cfg;
  logic             out_key_mode_inverse;
  logic             out_data_valid;
  logic             out_data_ready;
  logic [128*d-1:0] out_shares_data;
  logic             busy;

  modport master (
    output in_key_valid, in_key_data, in_key_size_cfg, in_key_mode_inverse,
    output in_data_valid, in_data, in_rnd_valid, in_rnd,
    output out_key_ready, out_data_ready,
    input  in_key_ready, in_data_ready, in_rnd_ready,
    input  out_key_valid, out_key_data, out_key_size_cfg, out_key_mode_inverse,
    input  out_data_valid, out_shares_data, busy
  );

  modport slave (
    input  in_key_valid, in_key_data, in_key_size_cfg, in_key_mode_inverse,
    input  in_data_valid, in_data, in_rnd_valid, in_rnd,
    input  out_key_ready, out_data_ready,
    output in_key_ready, in_data_ready, in_rnd_ready,
    output out_key_valid, out_key_data, out_key_size_cfg, out_key_mode_inverse,
    output out_data_valid, out_shares_data, busy
  );
endinterface

// File: rtl/smaesh_share_feeder.sv
// rtl/smaesh_share_feeder.sv - splits unmasked key words and data blocks into d boolean shares
module smaesh_share_feeder #(
  parameter int d = 2
) (
  input logic                 clk,
  input logic                 rst,
  smaesh_share_feeder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, KEY_LOAD, KEY_MASK, KEY_EMIT, DATA_MASK, DATA_EMIT} state_t;

  state_t           state, state_next;
  logic [2:0]       wc;
  logic [1:0]       sc;
  logic [2:0]       n_m1;
  logic [2:0]       word_lim;
  logic [1:0]       share_lim;
  logic [1:0]       cfg_q;
  logic             inv_q;
  logic [31:0]      kb [8];
  logic [31:0]      rb [d-1][8];
  logic [128*d-1:0] db;
  logic [31:0]      key_word;
  logic             key_fire, rnd_fire, emit_fire, data_fire, dout_fire;

  always_comb begin
    case (cfg_q)
      2'b01:   n_m1 = 3'd5;
      2'b10:   n_m1 = 3'd7;
      default: n_m1 = 3'd3;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next         = state;
    bus.in_key_ready   = 1'b0;
    bus.in_data_ready  = 1'b0;
    bus.in_rnd_ready   = 1'b0;
    bus.out_key_valid  = 1'b0;
    bus.out_data_valid = 1'b0;
    case (state)
      IDLE: begin
        // key jobs win; data is only offered when no key word is pending
        if (bus.in_key_valid) begin
          state_next = KEY_LOAD;
        end else begin
          bus.in_data_ready = rst;
          if (bus.in_data_valid && rst) state_next = DATA_MASK;
        end
      end
      KEY_LOAD: begin
        bus.in_key_ready = 1'b1;
        if (bus.in_key_valid && wc == n_m1) state_next = KEY_MASK;
      end
      KEY_MASK: begin
        bus.in_rnd_ready = 1'b1;
        if (bus.in_rnd_valid && wc == n_m1 && sc == 2'(d-2)) state_next = KEY_EMIT;
      end
      KEY_EMIT: begin
        bus.out_key_valid = 1'b1;
        if (bus.out_key_ready && wc == n_m1 && sc == 2'(d-1)) state_next = IDLE;
      end
      DATA_MASK: begin
        bus.in_rnd_ready = 1'b1;
        if (bus.in_rnd_valid && wc == 3'd3 && sc == 2'(d-2)) state_next = DATA_EMIT;
      end
      DATA_EMIT: begin
        bus.out_data_valid = 1'b1;
        if (bus.out_data_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign key_fire  = bus.in_key_valid  & bus.in_key_ready;
  assign rnd_fire  = bus.in_rnd_valid  & bus.in_rnd_ready;
  assign emit_fire = bus.out_key_valid & bus.out_key_ready;
  assign data_fire = bus.in_data_valid & bus.in_data_ready;
  assign dout_fire = bus.out_data_valid & bus.out_data_ready;

  assign word_lim  = (state == DATA_MASK) ? 3'd3 : n_m1;
  assign share_lim = (state == KEY_EMIT) ? 2'(d-1) : 2'(d-2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wc <= '0;
      sc <= '0;
    end else if (key_fire || rnd_fire || emit_fire) begin
      if (wc == word_lim) begin
        wc <= '0;
        sc <= (state == KEY_LOAD || sc == share_lim) ? 2'd0 : sc + 2'd1;
      end else begin
        wc <= wc + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_q <= '0;
      inv_q <= 1'b0;
      db    <= '0;
      for (int k = 0; k < 8; k++) begin
        kb[k] <= '0;
        for (int s = 0; s < d-1; s++) rb[s][k] <= '0;
      end
    end else begin
      if (key_fire) begin
        kb[wc] <= bus.in_key_data;
        if (wc == 3'd0) begin
          cfg_q <= bus.in_key_size_cfg;
          inv_q <= bus.in_key_mode_inverse;
        end
      end
      if (rnd_fire && state == KEY_MASK) begin
        kb[wc] <= kb[wc] ^ bus.in_rnd;
        for (int s = 0; s < d-1; s++)
          if (sc == 2'(s)) rb[s][wc] <= bus.in_rnd;
      end
      if (emit_fire && state_next == IDLE) begin
        for (int k = 0; k < 8; k++) begin
          kb[k] <= '0;
          for (int s = 0; s < d-1; s++) rb[s][k] <= '0;
        end
      end
      if (data_fire) db <= {{(128*(d-1)){1'b0}}, bus.in_data};
      if (rnd_fire && state == DATA_MASK) begin
        for (int s = 0; s < d-1; s++)
          for (int k = 0; k < 4; k++)
            if (sc == 2'(s) && wc == 3'(k)) begin
              db[128*(s+1)+32*k +: 32] <= bus.in_rnd;
              db[32*k +: 32]           <= db[32*k +: 32] ^ bus.in_rnd;
            end
      end
      if (dout_fire) db <= '0;
    end
  end

  // share 0 lives in kb, shares 1..d-1 in rb; nothing leaves outside KEY_EMIT
  always_comb begin
    key_word = kb[wc];
    for (int s = 0; s < d-1; s++)
      if (sc == 2'(s+1)) key_word = rb[s][wc];
  end

  assign bus.out_key_data         = (state == KEY_EMIT) ? key_word : 32'd0;
  assign bus.out_shares_data      = (state == DATA_EMIT) ? db : '0;
  assign bus.out_key_size_cfg     = cfg_q;
  assign bus.out_key_mode_inverse = inv_q;
  assign bus.busy                 = (state != IDLE);
endmodule

// File: tb/tb_smaesh_share_feeder.sv
// tb/tb_smaesh_share_feeder.sv - directed bench for the share feeder at d=2 and d=3
module tb_smaesh_share_feeder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  smaesh_share_feeder_if #(.d(2)) if2 ();
  smaesh_share_feeder_if #(.d(3)) if3 ();

  smaesh_share_feeder #(.d(2)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
  smaesh_share_feeder #(.d(3)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));

  logic         sel;
  logic         key_valid, key_inv, data_valid, rnd_valid, okr, odr;
  logic [1:0]   key_cfg;
  logic [31:0]  key_data, rnd;
  logic [127:0] data;

  assign if2.in_key_valid        = sel ? 1'b0 : key_valid;
  assign if3.in_key_valid        = sel ? key_valid : 1'b0;
  assign if2.in_rnd_valid        = sel ? 1'b0 : rnd_valid;
  assign if3.in_rnd_valid        = sel ? rnd_valid : 1'b0;
  assign if2.out_key_ready       = sel ? 1'b0 : okr;
  assign if3.out_key_ready       = sel ? okr : 1'b0;
  assign if2.in_data_valid       = data_valid;
  assign if3.in_data_valid       = 1'b0;
  assign if2.out_data_ready      = odr;
  assign if3.out_data_ready      = 1'b0;
  assign if2.in_key_data         = key_data;
  assign if3.in_key_data         = key_data;
  assign if2.in_key_size_cfg     = key_cfg;
  assign if3.in_key_size_cfg     = key_cfg;
  assign if2.in_key_mode_inverse = key_inv;
  assign if3.in_key_mode_inverse = key_inv;
  assign if2.in_rnd              = rnd;
  assign if3.in_rnd              = rnd;
  assign if2.in_data             = data;
  assign if3.in_data             = data;

  logic        key_ready, rnd_ready, okv, oinv, busy;
  logic [31:0] okd;
  logic [1:0]  ocfg;
  assign key_ready = sel ? if3.in_key_ready : if2.in_key_ready;
  assign rnd_ready = sel ? if3.in_rnd_ready : if2.in_rnd_ready;
  assign okv       = sel ? if3.out_key_valid : if2.out_key_valid;
  assign okd       = sel ? if3.out_key_data : if2.out_key_data;
  assign ocfg      = sel ? if3.out_key_size_cfg : if2.out_key_size_cfg;
  assign oinv      = sel ? if3.out_key_mode_inverse : if2.out_key_mode_inverse;
  assign busy      = sel ? if3.busy : if2.busy;

  logic [31:0] key_w [8];
  logic [31:0] rnd_w [24];
  logic [31:0] got [32];
  logic [31:0] exp_a [8];
  int          n_got;
  bit          saw_dready;
  int          pass_cnt = 0;
  int          tot_cnt  = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] req);
    tot_cnt++;
    if (obs === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, req);
  endtask

  task automatic key_job(input int n, input logic [1:0] cfg, input bit inv, input bit tog,
                         input bit rr, input int stop_at);
    int dd, i, cyc;
    dd = sel ? 3 : 2;
    i = 0;
    cyc = 0;
    key_valid = 1'b1;
    key_cfg = cfg;
    key_inv = inv;
    while (i < n && cyc < 400) begin
      key_data = key_w[i];
      if (i > 0) begin
        key_cfg = cfg ^ 2'b01;
        key_inv = ~inv;
      end
      @(negedge clk);
      if (key_ready) i++;
      if (!sel && if2.in_data_ready) saw_dready = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    key_valid = 1'b0;
    check("key_load_words", 256'(i), 256'(n));
    i = 0;
    while (i < (dd-1)*n && cyc < 400) begin
      rnd = rnd_w[i];
      rnd_valid = tog ? ~rnd_valid : 1'b1;
      @(negedge clk);
      if (rnd_valid && rnd_ready) i++;
      if (!sel && if2.in_data_ready) saw_dready = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    rnd_valid = 1'b0;
    n_got = 0;
    while (n_got < dd*n && n_got < stop_at && cyc < 400) begin
      okr = rr ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (okv && okr) begin
        got[n_got] = okd;
        n_got++;
      end
      if (!sel && if2.in_data_ready) saw_dready = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    okr = 1'b0;
  endtask

  task automatic data_job(input logic [127:0] din, input logic [255:0] req);
    int i, cyc;
    bit acc;
    acc = 1'b0;
    cyc = 0;
    data = din;
    data_valid = 1'b1;
    while (!acc && cyc < 100) begin
      @(negedge clk);
      if (if2.in_data_ready) acc = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    data_valid = 1'b0;
    check("data_accept", 256'(acc), 256'(1));
    i = 0;
    while (i < 4 && cyc < 100) begin
      rnd = rnd_w[i];
      rnd_valid = 1'b1;
      @(negedge clk);
      if (if2.in_rnd_ready) i++;
      @(posedge clk); #1;
      cyc++;
    end
    rnd_valid = 1'b0;
    odr = 1'b0;
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      check("data_valid_hold", 256'(if2.out_data_valid), 256'(1));
      check("data_shares_hold", 256'(if2.out_shares_data), req);
      @(posedge clk); #1;
    end
    odr = 1'b1;
    @(posedge clk); #1;
    odr = 1'b0;
    @(negedge clk);
    check("data_after_done", {if2.out_data_valid, if2.busy, if2.out_shares_data}, 256'(0));
  endtask

  initial begin
    sel = 1'b0; key_valid = 1'b0; key_inv = 1'b0; data_valid = 1'b0; rnd_valid = 1'b0;
    okr = 1'b0; odr = 1'b0; key_cfg = 2'b00; key_data = '0; rnd = '0; data = '0;
    saw_dready = 1'b0;
    exp_a = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C,
              32'h0, 32'h0, 32'h0, 32'h0};
    #1;
    check("reset_outputs", {if2.busy, if2.in_key_ready, if2.in_data_ready, if2.in_rnd_ready,
                            if2.out_key_valid, if2.out_data_valid, if2.out_key_size_cfg,
                            if2.out_key_mode_inverse, if2.out_key_data, if3.busy}, 256'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // d=2 key 00..0F, zero randomness: share 0 is the key, share 1 is zero
    for (int k = 0; k < 8; k++) key_w[k] = exp_a[k];
    for (int k = 0; k < 24; k++) rnd_w[k] = 32'h0;
    key_job(4, 2'b00, 1'b0, 1'b0, 1'b0, 99);
    check("kA_count", 256'(n_got), 256'(8));
    for (int k = 0; k < 8; k++) check($sformatf("kA_word%0d", k), 256'(got[k]), 256'(exp_a[k]));
    check("kA_cfg_inv", {ocfg, oinv, busy}, 256'(0));

    // d=2 256-bit key with randomness valid toggling every cycle
    for (int k = 0; k < 8; k++) begin
      key_w[k] = 32'hC0DE_0000 + 32'(k);
      rnd_w[k] = 32'h5A5A_5A5A ^ (32'h0101_0101 * 32'(k));
    end
    key_job(8, 2'b10, 1'b1, 1'b1, 1'b0, 99);
    check("kB_count", 256'(n_got), 256'(16));
    for (int k = 0; k < 8; k++) begin
      check($sformatf("kB_s0_w%0d", k), 256'(got[k]), 256'(key_w[k] ^ rnd_w[k]));
      check($sformatf("kB_s1_w%0d", k), 256'(got[8+k]), 256'(rnd_w[k]));
    end
    check("kB_cfg_inv", {ocfg, oinv}, 256'(3'b101));

    // d=3 256-bit key, random key, randomness and consumer back-pressure
    sel = 1'b1;
    for (int k = 0; k < 8; k++) key_w[k] = $urandom();
    for (int k = 0; k < 16; k++) rnd_w[k] = $urandom();
    key_job(8, 2'b10, 1'b1, 1'b0, 1'b1, 99);
    check("kC_count", 256'(n_got), 256'(24));
    for (int k = 0; k < 8; k++) begin
      check($sformatf("kC_xor_w%0d", k), 256'(got[k] ^ got[8+k] ^ got[16+k]), 256'(key_w[k]));
      check($sformatf("kC_s1_w%0d", k), 256'(got[8+k]), 256'(rnd_w[k]));
      check($sformatf("kC_s2_w%0d", k), 256'(got[16+k]), 256'(rnd_w[8+k]));
    end
    check("kC_cfg_inv", {ocfg, oinv}, 256'(3'b101));
    sel = 1'b0;

    // d=2 data block with A5 randomness, 5 cycles of consumer stall
    for (int k = 0; k < 4; k++) rnd_w[k] = 32'hA5A5_A5A5;
    data_job(128'h00112233445566778899AABBCCDDEEFF,
             {128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5, 128'hA5B48796E1F0C3D22D3C0F1E69784B5A});

    // key and data requested together: key first, data waits
    for (int k = 0; k < 8; k++) key_w[k] = exp_a[k];
    for (int k = 0; k < 24; k++) rnd_w[k] = 32'h0;
    saw_dready = 1'b0;
    data = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;
    data_valid = 1'b1;
    key_job(4, 2'b00, 1'b0, 1'b0, 1'b0, 99);
    check("kE_count", 256'(n_got), 256'(8));
    check("kE_word0", 256'(got[0]), 256'(32'h03020100));
    check("kE_no_data_ready", 256'(saw_dready), 256'(0));
    rnd_w[0] = 32'h1111_1111; rnd_w[1] = 32'h2222_2222;
    rnd_w[2] = 32'h3333_3333; rnd_w[3] = 32'h4444_4444;
    data_job(128'hFFFFFFFF_00000000_FFFFFFFF_00000000,
             {128'h44444444_33333333_22222222_11111111, 128'hBBBBBBBB_33333333_DDDDDDDD_11111111});

    // reset in the middle of KEY_EMIT, then a clean job
    for (int k = 0; k < 8; k++) begin
      key_w[k] = 32'hBEEF_0000 + 32'(k);
      rnd_w[k] = 32'h0F0F_0000 + 32'(k);
    end
    key_job(6, 2'b01, 1'b1, 1'b0, 1'b0, 2);
    check("kF_partial", 256'(n_got), 256'(2));
    check("kF_pre_reset", {okv, busy, ocfg, oinv}, 256'(5'b11011));
    #2 rst = 1'b0;
    #1;
    check("kF_async_reset", {okv, busy, key_ready, rnd_ready, if2.in_data_ready,
                             if2.out_data_valid, ocfg, oinv, okd}, 256'(0));
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("kF_idle_after", {okv, busy}, 256'(0));
    for (int k = 0; k < 8; k++) key_w[k] = exp_a[k];
    for (int k = 0; k < 24; k++) rnd_w[k] = 32'h0;
    key_job(4, 2'b00, 1'b0, 1'b0, 1'b0, 99);
    check("kG_count", 256'(n_got), 256'(8));
    for (int k = 0; k < 8; k++) check($sformatf("kG_word%0d", k), 256'(got[k]), 256'(exp_a[k]));

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/smaesh_share_feeder.md
SMAESH_SHARE_FEEDER -- requirements
Module: smaesh_share_feeder

Interface
REQ-001 SHALL have parameter d, default 2, number of shares; legal range 2..4.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_key_valid / in_key_ready  input / output  1 each  unmasked key word handshake.
REQ-005 SHALL have port in_key_data  input  32  unmasked key word, word 0 first.
REQ-006 SHALL have port in_key_size_cfg  input  2  key size: 00=128 (N=4), 01=192 (N=6), 10=256 (N=8), 11=treated as 128.
REQ-007 SHALL have port in_key_mode_inverse  input  1  decryption key schedule request.
REQ-008 SHALL have port in_data_valid / in_data_ready  input / output  1 each  unmasked block handshake.
REQ-009 SHALL have port in_data  input  128  unmasked block.
REQ-010 SHALL have port in_rnd_valid / in_rnd_ready  input / output  1 each  randomness handshake.
REQ-011 SHALL have port in_rnd  input  32  fresh random word.
REQ-012 SHALL have port out_key_valid / out_key_ready  output / input  1 each  masked key word stream to core.
REQ-013 SHALL have port out_key_data  output  32  masked key word.
REQ-014 SHALL have port out_key_size_cfg / out_key_mode_inverse  output  2 / 1  values latched from the job's first key word.
REQ-015 SHALL have port out_data_valid / out_data_ready  output / input  1 each  masked block handshake.
REQ-016 SHALL have port out_shares_data  output  128*d  masked block; share s at bits [128*s +: 128].
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, KEY_LOAD, KEY_MASK, KEY_EMIT, DATA_MASK, DATA_EMIT.
REQ-019 IDLE: in_key_valid=1 -> KEY_LOAD, with key taking priority; else in_data_valid=1 -> capture in_data with in_data_ready=1 for that cycle, then DATA_MASK.
REQ-020 In KEY_LOAD, in_key_ready=1; N words accepted into key buffer kb[0..N-1]; cfg/inverse latched on word 0 and ignored on later words; -> KEY_MASK after word N-1.
REQ-021 In KEY_MASK, in_rnd_ready=1; (d-1)*N words accepted, order share s=1..d-1, word k=0..N-1; each word r stored to rb[s][k] and kb[k] <= kb[k] ^ r; -> KEY_EMIT after last word.
REQ-022 In KEY_EMIT, out_key_valid=1; emitted d*N words: kb[0..N-1] (share 0), then rb[1][0..N-1] ... rb[d-1][0..N-1]; index advances only on out_key_valid&out_key_ready; -> IDLE after last word.
REQ-023 XOR of all d emitted shares for word k SHALL equal the unmasked word k.
REQ-024 In DATA_MASK, in_rnd_ready=1; 4*(d-1) words accepted, share s=1..d-1, word k=0..3 into bits [128*s+32*k +: 32]; each XORed into share 0 at [32*k +: 32]; -> DATA_EMIT after last.
REQ-025 In DATA_EMIT, out_data_valid=1, out_shares_data stable until out_data_ready=1; -> IDLE on handshake.
REQ-026 out_key_data, out_key_valid, out_data_valid SHALL be driven from registers/state only, never combinationally from any in_* valid.
REQ-027 in_key_ready, in_data_ready, in_rnd_ready SHALL be low outside their stated states; stalled in_rnd_valid=0 freezes progress with no word lost or duplicated.
REQ-028 Key and data buffers SHALL be zeroized on leaving KEY_EMIT and DATA_EMIT; out_shares_data reads 0 outside DATA_EMIT.
REQ-029 Word and share counters SHALL wrap to 0 on leaving each state; no counter exceeds d*N-1.
REQ-030 Minimum latency: key job N + (d-1)*N + d*N cycles; data job 1 + 4*(d-1) + 1 cycles.

Reset
REQ-031 rst=0 SHALL immediately force IDLE, all valid/ready outputs and busy to 0, all buffers and counters to 0, and out_key_size_cfg=00, out_key_mode_inverse=0.
REQ-032 Reset mid-job SHALL discard the job; after release no partial output is emitted.

Verification
REQ-033 d=2, cfg=00, key 000102..0F, rnd words all 0 -> out_key_data 03020100,07060504,0B0A0908,0F0E0D0C, then four 00000000.
REQ-034 d=3, cfg=10, random key and rnd, random out_key_ready -> 24 words emitted; per-word XOR of 3 shares equals key; inverse flag held on out_key_mode_inverse.
REQ-035 d=2, in_data=0x00112233..FF, rnd=A5A5A5A5 x4 -> share1 all A5, share0=in_data^{A5..}, out_data_valid held through 5 cycles of out_data_ready=0.
REQ-036 in_key_valid and in_data_valid asserted same cycle in IDLE -> key job served first, in_data_ready=0 until key job returns to IDLE.
REQ-037 in_rnd_valid toggling 1/0 every cycle in KEY_MASK -> exactly (d-1)*N words consumed, output correct.
REQ-038 rst=0 pulse in KEY_EMIT after 2 words -> all outputs 0 asynchronously; next job emits from word 0 with fresh buffers.
